// File: rtl/ternary_window_trigger.sv
// rtl/ternary_window_trigger.sv - sliding 16-sample boxcar power trigger with holdoff and scaler
module ternary_window_trigger #(
    parameter int WINDOW_LOG2  = 4,
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4:0]              SUM_I,
    input  logic                    SUM_VALID_I,
    input  logic [8:0]              THRESH_I,
    input  logic                    THRESH_WR_I,
    input  logic [HOLDOFF_BITS-1:0] HOLDOFF_I,
    input  logic                    SCALER_CLR_I,
    output logic [8:0]              POWER_O,
    output logic                    ARMED_O,
    output logic                    TRIG_O,
    output logic [15:0]             SCALER_O
);
    localparam int DEPTH = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2:0] FILL_FULL = (WINDOW_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_FILL, S_ARMED, S_HOLDOFF} state_t;

    logic [4:0]              line_q [DEPTH];
    logic [8:0]              power_q, power_d;
    logic [WINDOW_LOG2:0]    fill_q, fill_d;
    logic [8:0]              thresh_q;
    logic                    cmp_q;
    state_t                  state_q, state_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic                    trig_q, trig_d;
    logic [15:0]             scaler_q, scaler_d;

    // The last tap is zero while filling because the line resets to zero.
    always_comb begin
        power_d = power_q;
        fill_d  = fill_q;
        if (SUM_VALID_I) begin
            power_d = power_q + 9'(SUM_I) - 9'(line_q[DEPTH-1]);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + (WINDOW_LOG2+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
            power_q  <= '0;
            fill_q   <= '0;
            thresh_q <= 9'h1FF;
            cmp_q    <= 1'b0;
            hold_q   <= '0;
            trig_q   <= 1'b0;
            scaler_q <= '0;
        end else begin
            if (SUM_VALID_I) begin
                line_q[0] <= SUM_I;
                for (int i = 1; i < DEPTH; i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
            power_q  <= power_d;
            fill_q   <= fill_d;
            cmp_q    <= (power_q > thresh_q);
            if (THRESH_WR_I) begin
                thresh_q <= THRESH_I;
            end
            hold_q   <= hold_d;
            trig_q   <= trig_d;
            scaler_q <= scaler_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:    if (fill_d == FILL_FULL) state_d = S_ARMED;
            S_ARMED:   if (cmp_q && (HOLDOFF_I != '0)) state_d = S_HOLDOFF;
            S_HOLDOFF: if (hold_q <= HOLDOFF_BITS'(1)) state_d = S_ARMED;
            default:   state_d = S_FILL;
        endcase
    end

    // Holdoff counts clocks, not samples, so it runs regardless of SUM_VALID_I.
    always_comb begin
        trig_d = (state_q == S_ARMED) && cmp_q;
        hold_d = hold_q;
        if (trig_d) begin
            hold_d = HOLDOFF_I;
        end else if ((state_q == S_HOLDOFF) && (hold_q != '0)) begin
            hold_d = hold_q - HOLDOFF_BITS'(1);
        end
        scaler_d = scaler_q;
        if (SCALER_CLR_I) begin
            scaler_d = '0;
        end else if (trig_q && (scaler_q != 16'hFFFF)) begin
            scaler_d = scaler_q + 16'd1;
        end
    end

    assign POWER_O  = power_q;
    assign ARMED_O  = (state_q == S_ARMED);
    assign TRIG_O   = trig_q;
    assign SCALER_O = scaler_q;
endmodule

// File: tb/tb_ternary_window_trigger.sv
// tb/tb_ternary_window_trigger.sv - randomized and directed bench against a window/timing model
module tb_ternary_window_trigger;
    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  SUM_I;
    logic        SUM_VALID_I;
    logic [8:0]  THRESH_I;
    logic        THRESH_WR_I;
    logic [7:0]  HOLDOFF_I;
    logic        SCALER_CLR_I;
    logic [8:0]  POWER_O;
    logic        ARMED_O;
    logic        TRIG_O;
    logic [15:0] SCALER_O;

    ternary_window_trigger #(.WINDOW_LOG2(4), .HOLDOFF_BITS(8)) dut (
        .CLK(CLK), .RST(RST), .SUM_I(SUM_I), .SUM_VALID_I(SUM_VALID_I),
        .THRESH_I(THRESH_I), .THRESH_WR_I(THRESH_WR_I), .HOLDOFF_I(HOLDOFF_I),
        .SCALER_CLR_I(SCALER_CLR_I), .POWER_O(POWER_O), .ARMED_O(ARMED_O),
        .TRIG_O(TRIG_O), .SCALER_O(SCALER_O)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: window as a queue of the last 16 valid samples; holdoff as a time stamp.
    int win[$];
    int m_power, m_thresh, m_scaler, m_last_trig, m_last_hold, edge_n;
    bit m_cmp, m_trig, m_armed;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic step(input bit rst, input bit valid, input int sum, input bit wr,
                        input int th, input int hold, input bit clr);
        bit nt;
        int s;
        RST = rst; SUM_VALID_I = valid; SUM_I = 5'(sum);
        THRESH_WR_I = wr; THRESH_I = 9'(th); HOLDOFF_I = 8'(hold); SCALER_CLR_I = clr;
        @(posedge CLK);
        edge_n++;
        if (rst) begin
            win.delete();
            m_power = 0; m_thresh = 511; m_scaler = 0; m_cmp = 0; m_trig = 0; m_armed = 0;
            m_last_trig = -1000000; m_last_hold = 0;
        end else begin
            nt = m_armed && m_cmp;
            if (clr) m_scaler = 0;
            else if (m_trig && m_scaler < 65535) m_scaler++;
            m_cmp = (m_power > m_thresh);
            if (wr) m_thresh = th;
            if (valid) begin
                win.push_back(sum % 32);
                if (win.size() > 16) void'(win.pop_front());
                s = 0;
                foreach (win[i]) s += win[i];
                m_power = s % 512;
            end
            if (nt) begin
                m_last_trig = edge_n;
                m_last_hold = hold;
            end
            m_trig  = nt;
            m_armed = (win.size() == 16) && (edge_n >= m_last_trig + m_last_hold);
        end
        #1;
        check_eq("power", POWER_O, m_power);
        check_eq("armed", ARMED_O, m_armed);
        check_eq("trig", TRIG_O, m_trig);
        check_eq("scaler", SCALER_O, m_scaler);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int first_pw, first_tr, prev, seen;
        int trigs[$];
        edge_n = 0;
        RST = 1; SUM_I = 0; SUM_VALID_I = 0; THRESH_I = 0; THRESH_WR_I = 0;
        HOLDOFF_I = 0; SCALER_CLR_I = 0;
        #1;
        do_reset();
        check_eq("rst_power", POWER_O, 0);
        check_eq("rst_trig", TRIG_O, 0);
        check_eq("rst_armed", ARMED_O, 0);

        // Fill ramp with threshold 100
        step(0, 0, 0, 1, 100, 5, 0);
        first_pw = -1; first_tr = -1;
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 7, 0, 0, 5, 0);
            if (first_pw < 0 && POWER_O > 100) first_pw = i;
            if (first_tr < 0 && TRIG_O) first_tr = i;
            if (i < 15) check_eq("fill_no_arm", ARMED_O, 0);
        end
        check_eq("fill_trig_lat", first_tr - first_pw, 2);
        check_eq("fill_hold", POWER_O, 112);

        // Sliding window up and down
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1, 21, 0, 0, 0, 0);
        check_eq("slide_peak", POWER_O, 336);
        for (int i = 0; i < 16; i++) begin
            prev = POWER_O;
            step(0, 1, 0, 0, 0, 0, 0);
            check_eq("slide_dec", prev - POWER_O, 21);
        end

        // Holdoff 10 gives an 11-cycle trigger period
        do_reset();
        step(0, 0, 0, 1, 50, 10, 0);
        for (int i = 0; i < 80; i++) begin
            step(0, 1, 21, 0, 0, 10, 0);
            if (TRIG_O) trigs.push_back(edge_n);
        end
        check_eq("hold_count", (trigs.size() >= 4) ? 1 : 0, 1);
        for (int i = 1; i < trigs.size(); i++) check_eq("hold_period", trigs[i] - trigs[i-1], 11);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 21, 0, 0, 0, 0);
            if (i >= 10) check_eq("b2b_trig", TRIG_O, 1);
        end

        // Random valid gaps, holdoffs, threshold writes, clears and occasional resets
        do_reset();
        step(0, 0, 0, 1, 150, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 400) == 0, ($urandom % 10) < 7,
                 (($urandom % 25) == 0) ? 22 + int'($urandom % 10) : int'($urandom % 22),
                 ($urandom % 50) == 0, int'($urandom_range(40, 300)),
                 int'($urandom % 16), ($urandom % 100) == 0);
        end

        // Threshold boundary at 200
        do_reset();
        step(0, 0, 0, 1, 200, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, (i < 8) ? 13 : 12, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            idle();
            check_eq("eq_no_trig", TRIG_O, 0);
        end
        check_eq("eq_power", POWER_O, 200);
        step(0, 0, 0, 1, 199, 0, 0);
        check_eq("wr_old_thresh", TRIG_O, 0);
        idle();
        check_eq("wr_not_yet", TRIG_O, 0);
        idle();
        check_eq("wr_trig", TRIG_O, 1);

        // Reset threshold never fires
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(0, i < 16, 21, 0, 0, 0, 0);
            check_eq("rst_thr_no_trig", TRIG_O, 0);
        end
        check_eq("rst_thr_power", POWER_O, 336);

        // Scaler saturation, then clear coincident with a trigger
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 65560; i++) step(0, 1, 21, 0, 0, 0, 0);
        check_eq("scaler_sat", SCALER_O, 16'hFFFF);
        check_eq("sat_trig_on", TRIG_O, 1);
        step(0, 1, 21, 0, 0, 0, 1);
        check_eq("scaler_clr", SCALER_O, 0);

        // Reset in the middle of a long holdoff
        do_reset();
        step(0, 0, 0, 1, 50, 200, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 21, 0, 0, 200, 0);
            if (TRIG_O) seen = 1;
        end
        check_eq("ho_trig_seen", seen, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 21, 0, 0, 200, 0);
        check_eq("ho_in_holdoff", ARMED_O, 0);
        step(1, 1, 21, 0, 0, 200, 0);
        check_eq("ho_rst_power", POWER_O, 0);
        check_eq("ho_rst_armed", ARMED_O, 0);
        check_eq("ho_rst_trig", TRIG_O, 0);
        check_eq("ho_rst_scaler", SCALER_O, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 21, 0, 0, 0, 0);
            if (i < 15) check_eq("refill_no_arm", ARMED_O, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
